// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
//   Shared types and helpers for the ARC4 encrypt datapath.
//   - state_t      : top-level sequencer states
//   - swap_phase_t : four-step read-i / read-j / swap sequence of arc4_swap
//   - S_SIZE       : number of entries in the S permutation
//   - keybyte()    : key byte for S index i (MSB byte of the key first)
// -----------------------------------------------------------------------------
package arc4_pkg;

  localparam int S_SIZE  = 256;
  // Widest key (in bytes) keybyte() can index; the top zero-extends its key.
  localparam int KEY_MAX = 32;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    K_RI, K_LI, K_LJ, K_WJ,
    L_RD, L_LT,
    P_RI, P_LI, P_LJ, P_WJ, P_RP, P_LP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SW_RI,
    SW_LI,
    SW_LJ,
    SW_WJ
  } swap_phase_t;

  // Key byte used at S index idx. Byte 0 of the schedule is the most
  // significant byte of the keylen-byte key.
  function automatic logic [7:0] keybyte(input logic [8*KEY_MAX-1:0] key_ext,
                                         input int                   keylen,
                                         input logic [7:0]           idx);
    int                     pos;
    logic [8*KEY_MAX-1:0]   sh;
    pos = int'(idx) % keylen;
    sh  = key_ext >> (8 * (keylen - 1 - pos));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/arc4_swap.sv
// -----------------------------------------------------------------------------
// arc4_swap
//   Read-i / read-j / swap sequencer on the external S RAM, shared by KSA and
//   PRGA. A start pulse launches four cycles:
//     RI : s_addr = i
//     LI : si = S[i]; j = j + si + j_add; s_addr = j
//     LJ : S[i] <= S[j] (sj), latch sj
//     WJ : S[j] <= si, done = 1
//   j is held here; j_clr zeroes it between phases of the algorithm.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            first cycle of a swap (RI step drives i immediately)
//   j_clr            clear j to 0
//   i_idx            S index i for this swap
//   j_add            extra addend for j (key byte in KSA, 0 in PRGA)
//   s_rddata         S RAM read data (1-cycle latency)
//   s_addr/s_wrdata/s_wren  S RAM port while a swap is in progress, else 0
//   si, sj           values read from S[i] and S[j] by the last swap
//   done             high in the final (WJ) step
// -----------------------------------------------------------------------------
module arc4_swap
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       j_clr,
  input  logic [7:0] i_idx,
  input  logic [7:0] j_add,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] si,
  output logic [7:0] sj,
  output logic       done
);

  swap_phase_t phase_q;
  swap_phase_t phase;
  logic        active_q;
  logic [7:0]  j_q;
  logic [7:0]  j_next;
  logic [7:0]  si_q;
  logic [7:0]  sj_q;

  // The RI step happens in the start cycle itself, before active_q is set.
  assign phase = active_q ? phase_q : SW_RI;
  assign si    = si_q;
  assign sj    = sj_q;

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    done     = 1'b0;
    j_next   = j_q;
    if (active_q || start) begin
      case (phase)
        SW_RI: s_addr = i_idx;
        SW_LI: begin
          j_next = j_q + s_rddata + j_add;
          s_addr = j_next;
        end
        SW_LJ: begin
          s_addr   = i_idx;
          s_wrdata = s_rddata;
          s_wren   = 1'b1;
        end
        SW_WJ: begin
          s_addr   = j_q;
          s_wrdata = si_q;
          s_wren   = 1'b1;
          done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      active_q <= 1'b0;
      phase_q  <= SW_RI;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
    end else begin
      if (j_clr) begin
        j_q <= '0;
      end else if (active_q && phase_q == SW_LI) begin
        j_q <= j_next;
      end

      if (active_q) begin
        case (phase_q)
          SW_LI: begin
            si_q    <= s_rddata;
            phase_q <= SW_LJ;
          end
          SW_LJ: begin
            sj_q    <= s_rddata;
            phase_q <= SW_WJ;
          end
          SW_WJ: begin
            active_q <= 1'b0;
            phase_q  <= SW_RI;
          end
          default: phase_q <= SW_LI;
        endcase
      end else if (start) begin
        active_q <= 1'b1;
        phase_q  <= SW_LI;
      end
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// -----------------------------------------------------------------------------
// arc4_encrypt
//   Reads a length-prefixed plaintext (PT[0]=L, PT[1..L]) and writes the
//   length-prefixed ARC4 ciphertext (CT[0]=L, CT[k]=PT[k]^pad[k]) using an
//   external 256x8 S RAM: INIT (S[n]=n), KSA, length fetch, PRGA.
//   rdy is high in IDLE and DONE; en&rdy starts a run and latches key.
//   Optional feature macro: ARC4_ENC_CKSUM_EN adds the cksum output (XOR of
//   every byte written to CT, cleared on accept).
// Parameters
//   KEYLEN  key length in bytes (<= arc4_pkg::KEY_MAX)
//   AW      address width of the S/PT/CT memories (>= 8)
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   en, rdy                      start request / idle-or-done
//   key                          key, sampled on the accept edge
//   s_addr/s_wrdata/s_wren/s_rddata   S RAM (read latency 1)
//   pt_addr/pt_rddata            PT memory, read-only (read latency 1)
//   ct_addr/ct_wrdata/ct_wren    CT memory write port
//   cksum                        CT checksum (ARC4_ENC_CKSUM_EN only)
// -----------------------------------------------------------------------------
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEYLEN = 3,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [8*KEYLEN-1:0] key,
  output logic [AW-1:0]     s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        s_rddata,
  output logic [AW-1:0]     pt_addr,
  input  logic [7:0]        pt_rddata,
  output logic [AW-1:0]     ct_addr,
  output logic [7:0]        ct_wrdata,
  output logic              ct_wren
`ifdef ARC4_ENC_CKSUM_EN
  ,
  output logic [7:0]        cksum
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(S_SIZE - 1);

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            i_q;      // INIT n, KSA i, PRGA i (wraps to 0 between phases)
  logic [7:0]            k_q;      // PRGA byte index 1..L
  logic [7:0]            len_q;
  logic [7:0]            pt_q;
  logic [8*KEYLEN-1:0]   key_q;
  logic [8*KEY_MAX-1:0]  key_ext;
  logic                  accept;

  logic [7:0]            s_addr8;
  logic [7:0]            pt_addr8;
  logic [7:0]            ct_addr8;

  logic                  sw_start;
  logic                  sw_jclr;
  logic [7:0]            sw_iidx;
  logic [7:0]            sw_jadd;
  logic [7:0]            sw_addr;
  logic [7:0]            sw_wrdata;
  logic                  sw_wren;
  logic [7:0]            sw_si;
  logic [7:0]            sw_sj;
  logic                  sw_done;

  assign rdy    = (state_q == IDLE) || (state_q == DONE);
  assign accept = en && rdy;

  always_comb begin
    key_ext              = '0;
    key_ext[8*KEYLEN-1:0] = key_q;
  end

  // PRGA increments i in the RI step, and that step already addresses the
  // new i, so present i+1 combinationally there.
  assign sw_start = (state_q == K_RI) || (state_q == P_RI);
  assign sw_jclr  = accept || (state_q == L_LT);
  assign sw_iidx  = (state_q == P_RI) ? i_q + 8'd1 : i_q;
  assign sw_jadd  = (state_q == K_LI) ? keybyte(key_ext, KEYLEN, i_q) : 8'd0;

  arc4_swap u_swap (
    .clk      (clk),
    .rst      (rst),
    .start    (sw_start),
    .j_clr    (sw_jclr),
    .i_idx    (sw_iidx),
    .j_add    (sw_jadd),
    .s_rddata (s_rddata),
    .s_addr   (sw_addr),
    .s_wrdata (sw_wrdata),
    .s_wren   (sw_wren),
    .si       (sw_si),
    .sj       (sw_sj),
    .done     (sw_done)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? INIT : IDLE;
      INIT:       if (i_q == LAST_IDX) state_d = K_RI;
      K_RI:       state_d = K_LI;
      K_LI:       state_d = K_LJ;
      K_LJ:       state_d = K_WJ;
      K_WJ:       if (sw_done) state_d = (i_q == LAST_IDX) ? L_RD : K_RI;
      L_RD:       state_d = L_LT;
      L_LT:       state_d = (pt_rddata == 8'd0) ? DONE : P_RI;
      P_RI:       state_d = P_LI;
      P_LI:       state_d = P_LJ;
      P_LJ:       state_d = P_WJ;
      P_WJ:       if (sw_done) state_d = P_RP;
      P_RP:       state_d = P_LP;
      P_LP:       state_d = (k_q == len_q) ? DONE : P_RI;
      default:    state_d = IDLE;
    endcase
  end

  // Memory-port outputs
  always_comb begin
    s_addr8   = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr8  = '0;
    ct_addr8  = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state_q)
      INIT: begin
        s_addr8  = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
      end
      K_RI, K_LI, K_LJ, K_WJ, P_LI, P_LJ, P_WJ: begin
        s_addr8  = sw_addr;
        s_wrdata = sw_wrdata;
        s_wren   = sw_wren;
      end
      P_RI: begin
        s_addr8  = sw_addr;
        s_wrdata = sw_wrdata;
        s_wren   = sw_wren;
        pt_addr8 = k_q;
      end
      L_LT: begin
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      P_RP: s_addr8 = sw_si + sw_sj;
      P_LP: begin
        ct_addr8  = k_q;
        ct_wrdata = s_rddata ^ pt_q;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_addr  = AW'(s_addr8);
  assign pt_addr = AW'(pt_addr8);
  assign ct_addr = AW'(ct_addr8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        key_q <= key;
        i_q   <= '0;
      end
      case (state_q)
        INIT, K_WJ, P_RI: i_q <= i_q + 8'd1;
        L_LT: begin
          len_q <= pt_rddata;
          k_q   <= 8'd1;
        end
        P_LI: pt_q <= pt_rddata;
        P_LP: if (k_q != len_q) k_q <= k_q + 8'd1;
        default: ;
      endcase
    end
  end

`ifdef ARC4_ENC_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cksum <= '0;
    end else if (ct_wren) begin
      cksum <= cksum ^ ct_wrdata;
    end
  end
`endif

endmodule
